// File: rtl/io_image_transfer.sv
// io_image_transfer: moves process-image bytes between the physical I/O pins
// and the byte-wide image RAM, driven by the scan controller's STATE/COUNT.
// IN phase writes a frozen snapshot of the inputs; OUT phase gathers the
// output bytes into a shadow register and commits all 128 outputs at once.
module io_image_transfer #(
  parameter int                IMG_AW      = 12,
  parameter logic [IMG_AW-1:0] IN_BASE     = IMG_AW'(12'h000),
  parameter logic [IMG_AW-1:0] OUT_BASE    = IMG_AW'(12'h010),
  parameter int                SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              RUN,
  input  logic [1:0]        STATE,
  input  logic [4:0]        COUNT,
  input  logic [127:0]      PIN,
  output logic [IMG_AW-1:0] IMG_ADDR,
  output logic [7:0]        IMG_DIN,
  output logic              IMG_WE,
  output logic              IMG_RE,
  input  logic [7:0]        IMG_DOUT,
  output logic [127:0]      POUT,
  output logic              OUT_UPD,
  output logic [15:0]       SCAN_CNT
);

  typedef enum logic [1:0] {
    PH_OUT  = 2'b00,
    PH_PROG = 2'b01,
    PH_IN   = 2'b10,
    PH_INIT = 2'b11
  } phase_e;

  phase_e       phase;
  logic [3:0]   idx;
  logic         in_go;
  logic         out_go;
  logic         commit;
  logic         unused_count_msb;

  logic [127:0] sync_q [SYNC_STAGES];
  logic [127:0] snap;
  logic [127:0] shadow;
  logic [3:0]   rd_idx;
  logic         rd_vld;

  assign phase            = phase_e'(STATE);
  assign idx              = COUNT[3:0];
  assign unused_count_msb = COUNT[4];
  assign in_go            = RUN && (phase == PH_IN);
  assign out_go           = RUN && (phase == PH_OUT);
  // The last requested byte arrives on the same edge that publishes POUT.
  assign commit           = rd_vld && (rd_idx == 4'd15);

  // Metastability chain on the asynchronous pins; free-running, ignores RUN.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample its
      // predecessor's old value, so the chain really is SYNC_STAGES deep.
      sync_q[0] <= PIN;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Input snapshot: tracks the synchronised pins, frozen for the whole IN phase.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      snap <= '0;
    end else if (RUN && (phase != PH_IN)) begin
      snap <= sync_q[SYNC_STAGES-1];
    end
  end

  // Image RAM port: registered strobes, address, write data and read tag.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      IMG_ADDR <= '0;
      IMG_DIN  <= '0;
      IMG_WE   <= 1'b0;
      IMG_RE   <= 1'b0;
      rd_idx   <= '0;
      rd_vld   <= 1'b0;
    end else begin
      IMG_WE <= in_go;
      IMG_RE <= out_go;
      rd_vld <= out_go;
      if (in_go) begin
        IMG_ADDR <= IN_BASE + IMG_AW'(idx);
        IMG_DIN  <= snap[{idx, 3'b000} +: 8];
      end else if (out_go) begin
        IMG_ADDR <= OUT_BASE + IMG_AW'(idx);
        rd_idx   <= idx;
      end
    end
  end

  // Shadow capture of returned bytes and atomic commit of the output image.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      // NOTE: shadow is a plain register bank, not a RAM, so it is cleared
      // with everything else; an aborted scan then leaves no stale bytes.
      shadow   <= '0;
      POUT     <= '0;
      OUT_UPD  <= 1'b0;
      SCAN_CNT <= '0;
    end else begin
      OUT_UPD <= commit;
      if (rd_vld) shadow[{rd_idx, 3'b000} +: 8] <= IMG_DOUT;
      if (commit) begin
        POUT     <= {IMG_DOUT, shadow[119:0]};
        SCAN_CNT <= SCAN_CNT + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_io_image_transfer.sv
// Self-checking bench for io_image_transfer: directed and randomized IN/OUT
// scans against a byte-level reference of the expected RAM traffic and image.
module tb_io_image_transfer;

  localparam logic [11:0] IN_BASE  = 12'h000;
  localparam logic [11:0] OUT_BASE = 12'h010;
  localparam logic [1:0]  ST_INIT  = 2'b11;
  localparam logic [1:0]  ST_IN    = 2'b10;
  localparam logic [1:0]  ST_PROG  = 2'b01;
  localparam logic [1:0]  ST_OUT   = 2'b00;

  logic         CLK = 1'b0;
  logic         CLR;
  logic         RUN;
  logic [1:0]   STATE;
  logic [4:0]   COUNT;
  logic [127:0] PIN;
  logic [11:0]  IMG_ADDR;
  logic [7:0]   IMG_DIN;
  logic         IMG_WE;
  logic         IMG_RE;
  logic [7:0]   IMG_DOUT;
  logic [127:0] POUT;
  logic         OUT_UPD;
  logic [15:0]  SCAN_CNT;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: last committed image and number of commits.
  logic [127:0] exp_pout;
  int           exp_scan;

  logic [7:0] mem [4096];

  io_image_transfer #(
    .IMG_AW(12), .IN_BASE(IN_BASE), .OUT_BASE(OUT_BASE), .SYNC_STAGES(2)
  ) dut (
    .CLK(CLK), .CLR(CLR), .RUN(RUN), .STATE(STATE), .COUNT(COUNT), .PIN(PIN),
    .IMG_ADDR(IMG_ADDR), .IMG_DIN(IMG_DIN), .IMG_WE(IMG_WE), .IMG_RE(IMG_RE),
    .IMG_DOUT(IMG_DOUT), .POUT(POUT), .OUT_UPD(OUT_UPD), .SCAN_CNT(SCAN_CNT)
  );

  always #5 CLK = ~CLK;

  // Image RAM model: writes on the clock, read data presented during the
  // cycle the registered read strobe is high.
  always @(posedge CLK) if (IMG_WE) mem[IMG_ADDR] <= IMG_DIN;
  assign IMG_DOUT = IMG_RE ? mem[IMG_ADDR] : 8'h5A;

  // Write and read strobes must never overlap.
  always @(negedge CLK) begin
    if (CLR === 1'b0) begin
      n_cmp++;
      if (IMG_WE && IMG_RE) begin
        n_err++;
        $display("FAIL we_re_exclusive: got WE=%b RE=%b want not both 1", IMG_WE, IMG_RE);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // One clock: apply controller inputs, clock, observe just after the edge.
  task automatic cyc(input logic [1:0] st, input int c, input logic run);
    STATE = st;
    COUNT = 5'(c);
    RUN   = run;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    CLR = 1'b1; RUN = 1'b0; STATE = ST_PROG; COUNT = '0; PIN = '0;
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++; if (IMG_ADDR !== 12'h000) begin n_err++; $display("FAIL reset_addr: got %h want 000", IMG_ADDR); end
    n_cmp++; if (IMG_DIN !== 8'h00) begin n_err++; $display("FAIL reset_din: got %h want 00", IMG_DIN); end
    n_cmp++; if (IMG_WE !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", IMG_WE); end
    n_cmp++; if (IMG_RE !== 1'b0) begin n_err++; $display("FAIL reset_re: got %b want 0", IMG_RE); end
    n_cmp++; if (POUT !== 128'h0) begin n_err++; $display("FAIL reset_pout: got %h want 0", POUT); end
    n_cmp++; if (OUT_UPD !== 1'b0) begin n_err++; $display("FAIL reset_upd: got %b want 0", OUT_UPD); end
    n_cmp++; if (SCAN_CNT !== 16'h0) begin n_err++; $display("FAIL reset_scan: got %h want 0", SCAN_CNT); end
    @(negedge CLK);
    CLR = 1'b0;
    exp_pout = '0;
    exp_scan = 0;
  endtask

  // INIT and PROG leave the RAM to the CPU: no strobes at all.
  task automatic test_idle();
    for (int i = 0; i < 6; i++) begin
      cyc((i < 3) ? ST_INIT : ST_PROG, $urandom_range(0, 31), 1'b1);
      n_cmp++;
      if (IMG_WE !== 1'b0 || IMG_RE !== 1'b0 || OUT_UPD !== 1'b0) begin
        n_err++;
        $display("FAIL idle_strobes: got WE=%b RE=%b UPD=%b want 0 0 0", IMG_WE, IMG_RE, OUT_UPD);
      end
    end
  endtask

  // IN phase: pins held stable in PROG, then 16 writes of the frozen sample;
  // the pins jump to all-ones at COUNT=toggle_at without affecting the data.
  task automatic test_in_phase(input logic [127:0] pv, input int toggle_at);
    PIN = pv;
    repeat (4) cyc(ST_PROG, 0, 1'b1);
    for (int c = 0; c < 16; c++) begin
      if (c == toggle_at) PIN = '1;
      cyc(ST_IN, c, 1'b1);
      n_cmp++;
      if (IMG_WE !== 1'b1 || IMG_RE !== 1'b0) begin
        n_err++;
        $display("FAIL in_strobe[%0d]: got WE=%b RE=%b want 1 0", c, IMG_WE, IMG_RE);
      end
      n_cmp++;
      if (IMG_ADDR !== IN_BASE + 12'(c)) begin
        n_err++;
        $display("FAIL in_addr[%0d]: got %h want %h", c, IMG_ADDR, IN_BASE + 12'(c));
      end
      n_cmp++;
      if (IMG_DIN !== pv[8*c +: 8]) begin
        n_err++;
        $display("FAIL in_data[%0d]: got %h want %h", c, IMG_DIN, pv[8*c +: 8]);
      end
    end
    cyc(ST_PROG, 0, 1'b1);
    n_cmp++;
    if (IMG_WE !== 1'b0) begin n_err++; $display("FAIL in_end_we: got %b want 0", IMG_WE); end
    for (int c = 0; c < 16; c++) begin
      n_cmp++;
      if (mem[IN_BASE + 12'(c)] !== pv[8*c +: 8]) begin
        n_err++;
        $display("FAIL in_ram[%0d]: got %h want %h", c, mem[IN_BASE + 12'(c)], pv[8*c +: 8]);
      end
    end
  endtask

  // OUT phase over 16 bytes, optional RUN stall of stall_len cycles at
  // COUNT=stall_at, then the controller moves on to next_st.
  task automatic test_out_phase(input bit directed, input int stall_at, input int stall_len,
                                input logic [1:0] next_st, input logic next_run);
    logic [127:0] new_img;
    for (int k = 0; k < 16; k++) begin
      new_img[8*k +: 8] = directed ? 8'(8'hA0 + k) : 8'($urandom);
      mem[OUT_BASE + 12'(k)] = new_img[8*k +: 8];
    end
    cyc(ST_PROG, 0, 1'b1);
    for (int c = 0; c < 16; c++) begin
      if (c == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          cyc(ST_OUT, c, 1'b0);
          n_cmp++;
          if (IMG_RE !== 1'b0 || IMG_WE !== 1'b0 || OUT_UPD !== 1'b0) begin
            n_err++;
            $display("FAIL out_stall[%0d]: got RE=%b WE=%b UPD=%b want 0 0 0", c, IMG_RE, IMG_WE, OUT_UPD);
          end
          n_cmp++;
          if (POUT !== exp_pout) begin n_err++; $display("FAIL out_stall_pout: got %h want %h", POUT, exp_pout); end
        end
      end
      cyc(ST_OUT, c, 1'b1);
      n_cmp++;
      if (IMG_RE !== 1'b1 || IMG_ADDR !== OUT_BASE + 12'(c)) begin
        n_err++;
        $display("FAIL out_read[%0d]: got RE=%b addr=%h want 1 %h", c, IMG_RE, IMG_ADDR, OUT_BASE + 12'(c));
      end
      n_cmp++;
      if (OUT_UPD !== 1'b0 || POUT !== exp_pout) begin
        n_err++;
        $display("FAIL out_hold[%0d]: got UPD=%b pout=%h want 0 %h", c, OUT_UPD, POUT, exp_pout);
      end
    end
    cyc(next_st, 0, next_run);
    n_cmp++;
    if (OUT_UPD !== 1'b1) begin n_err++; $display("FAIL out_upd: got %b want 1", OUT_UPD); end
    n_cmp++;
    if (POUT !== new_img) begin n_err++; $display("FAIL out_pout: got %h want %h", POUT, new_img); end
    n_cmp++;
    if (SCAN_CNT !== 16'(exp_scan + 1)) begin
      n_err++;
      $display("FAIL out_scan: got %h want %h", SCAN_CNT, 16'(exp_scan + 1));
    end
    exp_pout = new_img;
    exp_scan = (exp_scan + 1) % 65536;
    cyc(ST_PROG, 0, 1'b1);
    n_cmp++;
    if (OUT_UPD !== 1'b0 || POUT !== exp_pout) begin
      n_err++;
      $display("FAIL out_after: got UPD=%b pout=%h want 0 %h", OUT_UPD, POUT, exp_pout);
    end
  endtask

  // CLR in the middle of an OUT scan: immediate clear, no commit afterwards.
  task automatic test_clr_mid_out();
    for (int k = 0; k < 16; k++) mem[OUT_BASE + 12'(k)] = 8'($urandom);
    for (int c = 0; c <= 7; c++) cyc(ST_OUT, c, 1'b1);
    #2;
    CLR = 1'b1;
    #1;
    n_cmp++; if (POUT !== 128'h0) begin n_err++; $display("FAIL clr_pout: got %h want 0", POUT); end
    n_cmp++; if (SCAN_CNT !== 16'h0) begin n_err++; $display("FAIL clr_scan: got %h want 0", SCAN_CNT); end
    n_cmp++;
    if (IMG_RE !== 1'b0 || IMG_ADDR !== 12'h000 || OUT_UPD !== 1'b0) begin
      n_err++;
      $display("FAIL clr_port: got RE=%b addr=%h UPD=%b want 0 000 0", IMG_RE, IMG_ADDR, OUT_UPD);
    end
    @(negedge CLK);
    CLR = 1'b0;
    exp_pout = '0;
    exp_scan = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(ST_PROG, 8 + i, 1'b1);
      n_cmp++;
      if (POUT !== 128'h0 || OUT_UPD !== 1'b0) begin
        n_err++;
        $display("FAIL clr_after: got pout=%h UPD=%b want 0 0", POUT, OUT_UPD);
      end
    end
  endtask

  // Counter wrap: preset the scan counter to FFFF, next commit gives 0000.
  task automatic test_scan_wrap();
    force dut.SCAN_CNT = 16'hFFFF;
    #1;
    release dut.SCAN_CNT;
    exp_scan = 65535;
    test_out_phase(1'b0, 99, 0, ST_PROG, 1'b1);
    n_cmp++;
    if (SCAN_CNT !== 16'h0000) begin n_err++; $display("FAIL scan_wrap: got %h want 0000", SCAN_CNT); end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
    CLR = 1'b1; RUN = 1'b0; STATE = ST_PROG; COUNT = '0; PIN = '0;
    exp_pout = '0;
    exp_scan = 0;

    test_reset();
    test_idle();
    test_in_phase(128'h0F0E0D0C0B0A09080706050403020100, -1);
    test_in_phase(128'h0F0E0D0C0B0A09080706050403020100, 5);
    test_in_phase({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 15));
    test_out_phase(1'b1, 99, 0, ST_IN, 1'b1);
    test_out_phase(1'b1, 9, 3, ST_PROG, 1'b1);
    test_clr_mid_out();
    for (int r = 0; r < 5; r++) begin
      test_out_phase(1'b0, $urandom_range(0, 20), $urandom_range(1, 3),
                     ($urandom_range(0, 1) == 1) ? ST_IN : ST_PROG, 1'($urandom_range(0, 1)));
      test_in_phase({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 16));
    end
    test_scan_wrap();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
